// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_ctrl_pkg                                                             |
// | Shared definitions for the 16K-word RAM controllers: RAM geometry and    |
// | the block-copier state encoding.                                         |
// | Ports: none (package).                                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package ram_ctrl_pkg;

  localparam int RAM16K_ADDR_W = 14;
  localparam int RAM16K_DATA_W = 16;

  // FILL only becomes reachable when RAM16K_COPIER_FILL_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_FILL  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram16k_block_copier_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram16k_block_copier_if                                                   |
// | Word-wide bus between the block copier and a fast_ram16k instance.       |
// | Signals: mem_address, mem_in, mem_load (initiator -> RAM),               |
// |          mem_out (RAM -> initiator, combinational read of mem_address).  |
// | Modports: master (copier side), slave (RAM side).                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface ram16k_block_copier_if #(
  parameter int ADDR_W = ram_ctrl_pkg::RAM16K_ADDR_W,
  parameter int DATA_W = ram_ctrl_pkg::RAM16K_DATA_W
);

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  modport master (output mem_address, output mem_in, output mem_load, input mem_out);
  modport slave  (input mem_address, input mem_in, input mem_load, output mem_out);

endinterface
`default_nettype wire

// File: rtl/ram_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_addr_gen                                                             |
// | Address sequencer for the block copier. Latches the start addresses,     |
// | copy direction and word count, and walks the source/destination          |
// | pointers one word per step (modulo 2^ADDR_W).                            |
// | Ports: clk, reset (sync, active-high); load/src/dst/len/fill_mode latch  |
// |        a new transfer; step advances one word; src_addr/dst_addr are the |
// |        current word addresses; last flags the final word.               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ram_addr_gen
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM16K_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic              fill_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic              last
);

  logic              descending;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] len_m1;
  logic              go_down;

  // len=16384 has a zero low slice, so len_m1 wraps to 16383 as required.
  assign len_m1  = len[ADDR_W-1:0] - 1'b1;
  // Direction uses the raw start addresses, not the wrapped ranges; fills
  // always ascend.
  assign go_down = !fill_mode && (dst > src);
  assign last    = (count == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      src_addr   <= '0;
      dst_addr   <= '0;
      descending <= 1'b0;
      count      <= '0;
    end else if (load) begin
      descending <= go_down;
      count      <= len;
      src_addr   <= go_down ? src + len_m1 : src;
      dst_addr   <= go_down ? dst + len_m1 : dst;
    end else if (step) begin
      count <= count - 1'b1;
      if (descending) begin
        src_addr <= src_addr - 1'b1;
        dst_addr <= dst_addr - 1'b1;
      end else begin
        src_addr <= src_addr + 1'b1;
        dst_addr <= dst_addr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram16k_block_copier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram16k_block_copier                                                      |
// | memmove-style block copy engine for a 16K x 16 RAM: one start pulse      |
// | moves len words (0..16384) from src to dst, two cycles per word.         |
// | Ports: clk, reset (sync, active-high); start/src/dst/len request;        |
// |        busy/done status; mem (master modport) drives the RAM.            |
// | Optional: RAM16K_COPIER_FILL_EN adds fill/fill_value and a FILL state    |
// |        writing fill_value to dst.. at one word per cycle.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module ram16k_block_copier
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM16K_ADDR_W,
  parameter int DATA_W = RAM16K_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
`ifdef RAM16K_COPIER_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  ram16k_block_copier_if.master mem
);

  state_t            state;
  logic [DATA_W-1:0] data_reg;
  logic              accept;
  logic              fill_req;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign accept = (state == ST_IDLE) && start;
  assign step   = (state == ST_WRITE) || (state == ST_FILL);

`ifdef RAM16K_COPIER_FILL_EN
  assign fill_req = fill;
`else
  assign fill_req = 1'b0;
`endif

  ram_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_mode (fill_req),
    .step      (step),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
`ifdef RAM16K_COPIER_FILL_EN
            else if (fill) begin
              // The fill word rides in the data register so mem_in needs no mux.
              state    <= ST_FILL;
              busy     <= 1'b1;
              data_reg <= fill_value;
            end
`endif
            else begin
              state <= ST_READ;
              busy  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          data_reg <= mem.mem_out;
          state    <= ST_WRITE;
        end
        ST_WRITE, ST_FILL: begin
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (state == ST_WRITE) begin
            state <= ST_READ;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // RAM controls decode from registered state only; start never reaches them.
  always_comb begin
    mem.mem_address = '0;
    case (state)
      ST_READ:           mem.mem_address = src_addr;
      ST_WRITE, ST_FILL: mem.mem_address = dst_addr;
      default:           mem.mem_address = '0;
    endcase
  end

  assign mem.mem_in   = data_reg;
  // Gating with reset keeps a reset cycle from committing a write.
  assign mem.mem_load = ((state == ST_WRITE) || (state == ST_FILL)) && !reset;

endmodule
`default_nettype wire

// File: tb/tb_ram16k_block_copier.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram16k_block_copier                                                   |
// | Self-checking bench: a RAM model on the bus, directed scenarios and      |
// | random copies checked against a word-order reference model.             |
// | Define RAM16K_COPIER_FILL_EN to also exercise the FILL feature.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ram16k_block_copier;

  localparam int N    = 16384;
  localparam int MASK = N - 1;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] src   = '0;
  logic [13:0] dst   = '0;
  logic [14:0] len   = '0;
  logic        busy;
  logic        done;
`ifdef RAM16K_COPIER_FILL_EN
  logic        fill       = 1'b0;
  logic [15:0] fill_value = '0;
`endif

  logic        pre_we   = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  logic [15:0] ram     [0:N-1];
  logic [15:0] exp_mem [0:N-1];
  int          rd_exp[$], wr_exp[$], rd_got[$], wr_got[$];

  int n_checks = 0;
  int n_errors = 0;

  ram16k_block_copier_if bus ();

  ram16k_block_copier dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
`ifdef RAM16K_COPIER_FILL_EN
    .fill       (fill),
    .fill_value (fill_value),
`endif
    .busy       (busy),
    .done       (done),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on the rising edge.
  assign bus.mem_out = ram[bus.mem_address];
  always @(posedge clk) begin
    if (bus.mem_load) ram[bus.mem_address] <= bus.mem_in;
    else if (pre_we)  ram[pre_addr] <= pre_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input int a, input logic [15:0] v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = 14'(a & MASK);
    pre_data = v;
  endtask

  task automatic poke_end();
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  function automatic int mem_diff();
    int e = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== exp_mem[i]) e++;
    return e;
  endfunction

  function automatic int q_diff(input int a[$], input int b[$]);
    int e = (a.size() == b.size()) ? 0 : 1;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) e++;
    return e;
  endfunction

  // Reference: apply the transfer word by word in the order the rules give.
  task automatic run_copy(input int s, input int d, input int n,
                          input bit fill_mode, input logic [15:0] fv,
                          input bit start_again);
    bit desc;
    int idx, sa, da, exp_done, done_cyc, loads, busy_at_done;
    desc = !fill_mode && (d > s);
    rd_exp.delete(); wr_exp.delete(); rd_got.delete(); wr_got.delete();
    for (int i = 0; i < N; i++) exp_mem[i] = ram[i];
    for (int k = 0; k < n; k++) begin
      idx = desc ? n - 1 - k : k;
      sa  = (s + idx) & MASK;
      da  = (d + idx) & MASK;
      if (!fill_mode) rd_exp.push_back(sa);
      wr_exp.push_back(da);
      exp_mem[da] = fill_mode ? fv : exp_mem[sa];
    end
    exp_done = (n == 0) ? 1 : (fill_mode ? n + 1 : 2 * n + 1);

    @(negedge clk);
    src = 14'(s); dst = 14'(d); len = 15'(n); start = 1'b1;
`ifdef RAM16K_COPIER_FILL_EN
    fill = fill_mode; fill_value = fv;
`endif
    @(posedge clk);
    done_cyc = 0; loads = 0; busy_at_done = 0;
    for (int cyc = 1; cyc <= exp_done + 8 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (bus.mem_load)  begin loads++; wr_got.push_back(int'(bus.mem_address)); end
      else if (busy)     rd_got.push_back(int'(bus.mem_address));
      if (done) begin done_cyc = cyc; busy_at_done = int'(busy); end
      if (cyc == 1) start = 1'b0;
      if (start_again && cyc == 3) begin
        start = 1'b1;
        src   = 14'($urandom);
        dst   = 14'($urandom);
        len   = 15'($urandom_range(1, 40));
      end
      if (cyc == 4) start = 1'b0;
    end
    start = 1'b0;
    check("done_cycle", done_cyc, exp_done);
    check("busy_at_done", busy_at_done, 0);
    check("load_cycles", loads, n);
    check("read_order", q_diff(rd_got, rd_exp), 0);
    check("write_order", q_diff(wr_got, wr_exp), 0);
    @(negedge clk);
    check("idle_after_done", int'({busy, done, bus.mem_load}), 0);
    check("mem_contents", mem_diff(), 0);
  endtask

  initial begin
    int s, d, n;
    logic [15:0] v;

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_load", int'(bus.mem_load), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", int'(bus.mem_address), 0);
    check("rst_mem_in", int'(bus.mem_in), 0);
    check("idle_load", int'(bus.mem_load), 0);

    // Plain copy.
    poke(16'h0800, 16'd1); poke(16'h0801, 16'd3); poke(16'h0802, 16'd7); poke(16'h0803, 16'd15);
    poke_end();
    run_copy(16'h0800, 16'h1000, 4, 1'b0, 16'h0, 1'b0);
    check("copy_w0", int'(ram[14'h1000]), 1);
    check("copy_w3", int'(ram[14'h1003]), 15);

    // Overlapping forward move.
    for (int i = 0; i < 5; i++) poke(16'h0010 + i, 16'(i + 1));
    poke_end();
    run_copy(16'h0010, 16'h0012, 5, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) check("overlap_word", int'(ram[14'h0012 + 14'(i)]), i + 1);

    // Source range wrapping past the top of memory.
    poke(16'h3FFE, 16'hA001); poke(16'h3FFF, 16'hA002); poke(16'h0000, 16'hA003); poke(16'h0001, 16'hA004);
    poke_end();
    run_copy(16'h3FFE, 16'h2000, 4, 1'b0, 16'h0, 1'b0);
    check("wrap_w2", int'(ram[14'h2002]), 16'hA003);

    // Empty transfer, then a restart attempt in the middle of a copy.
    run_copy(16'h0100, 16'h0200, 0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 6; i++) poke(16'h0400 + i, 16'($urandom));
    poke_end();
    run_copy(16'h0400, 16'h0500, 6, 1'b0, 16'h0, 1'b1);

    // Reset in cycle 4 of a 4-word ascending copy: only word 0 lands.
    for (int i = 0; i < 4; i++) poke(16'h0600 + i, 16'hC000 + 16'(i));
    poke(16'h0200, 16'h0); poke(16'h0201, 16'h0);
    poke_end();
    for (int i = 0; i < N; i++) exp_mem[i] = ram[i];
    exp_mem[14'h0200] = 16'hC000;
    @(negedge clk);
    src = 14'h0600; dst = 14'h0200; len = 15'd4; start = 1'b1;
`ifdef RAM16K_COPIER_FILL_EN
    fill = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_cycle_load", int'(bus.mem_load), 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_addr", int'(bus.mem_address), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_load", int'(bus.mem_load), 0);
    check("post_rst_busy", int'(busy), 0);
    check("rst_mem_contents", mem_diff(), 0);

    // Random transfers, mixing overlapping and arbitrary destinations.
    for (int t = 0; t < 20; t++) begin
      s = $urandom_range(0, MASK);
      n = $urandom_range(1, 24);
      if (t % 2 == 0) d = (s + $urandom_range(0, 16) - 8) & MASK;
      else            d = $urandom_range(0, MASK);
      for (int i = 0; i < n; i++) begin
        v = 16'($urandom);
        poke(s + i, v);
      end
      poke_end();
      run_copy(s, d, n, 1'b0, 16'h0, (t % 3 == 0) && (n >= 3));
    end

`ifdef RAM16K_COPIER_FILL_EN
    run_copy(16'h0000, 16'h0100, 3, 1'b1, 16'h00FF, 1'b0);
    check("fill_w1", int'(ram[14'h0101]), 16'h00FF);
    for (int t = 0; t < 4; t++)
      run_copy($urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(1, 20),
               1'b1, 16'($urandom), 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
